// File: rtl/r4_stride_commutator_pkg.sv
// Shared FFT constants and helpers for the radix-4 commutator stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package r4_stride_commutator_pkg;

    localparam int RADIX      = 4;
    localparam int DEF_DATA_W = 32;

    // Ceiling log2 usable in constant expressions; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Enable-gated shift register with taps delayed STRIDE, 2*STRIDE and 3*STRIDE samples.
// Latency: taps are combinational views of stored samples; the shift happens on enabled edges.
// Backpressure: none; en=0 freezes the contents.
module fft_delay_line #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 12,
    parameter int STRIDE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap_s,
    output logic [WIDTH-1:0] tap_2s,
    output logic [WIDTH-1:0] tap_3s
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // mem[0] holds the previous sample, so mem[d-1] is d samples behind din.
    assign tap_s  = mem[STRIDE-1];
    assign tap_2s = mem[2*STRIDE-1];
    assign tap_3s = mem[3*STRIDE-1];

endmodule

// File: rtl/r4_stride_commutator.sv
// Gathers four stream samples spaced STRIDE apart and presents them in parallel to a radix-4 butterfly.
// Latency: one cycle from the accepting edge of the newest member to out_valid.
// Backpressure: none; in_valid gates the stream and the consumer must take every out_valid cycle.
module r4_stride_commutator
    import r4_stride_commutator_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  STRIDE = 4,
    localparam int CNT_W  = clog2(RADIX * STRIDE),
    localparam int IDX_W  = (STRIDE > 1) ? clog2(STRIDE) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    output logic              out_sof,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_x0_re,
    output logic [DATA_W-1:0] out_x0_im,
    output logic [DATA_W-1:0] out_x1_re,
    output logic [DATA_W-1:0] out_x1_im,
    output logic [DATA_W-1:0] out_x2_re,
    output logic [DATA_W-1:0] out_x2_im,
    output logic [DATA_W-1:0] out_x3_re,
    output logic [DATA_W-1:0] out_x3_im,
    output logic              out_err
);

    localparam logic [CNT_W-1:0] EMIT_K = CNT_W'(3 * STRIDE);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  k;
    logic [DATA_W-1:0] re_s, re_2s, re_3s;
    logic [DATA_W-1:0] im_s, im_2s, im_3s;

    // A block length of 4*STRIDE is a power of two, so the counter wraps naturally.
    assign k = in_sof ? '0 : cnt;

    fft_delay_line #(.WIDTH(DATA_W), .DEPTH(3 * STRIDE), .STRIDE(STRIDE)) u_dl_re (
        .clk    (clk),
        .reset  (reset),
        .en     (in_valid),
        .din    (in_re),
        .tap_s  (re_s),
        .tap_2s (re_2s),
        .tap_3s (re_3s)
    );

    fft_delay_line #(.WIDTH(DATA_W), .DEPTH(3 * STRIDE), .STRIDE(STRIDE)) u_dl_im (
        .clk    (clk),
        .reset  (reset),
        .en     (in_valid),
        .din    (in_im),
        .tap_s  (im_s),
        .tap_2s (im_2s),
        .tap_3s (im_3s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_err   <= 1'b0;
            out_idx   <= '0;
            out_x0_re <= '0;
            out_x0_im <= '0;
            out_x1_re <= '0;
            out_x1_im <= '0;
            out_x2_re <= '0;
            out_x2_im <= '0;
            out_x3_re <= '0;
            out_x3_im <= '0;
        end else begin
            // Only the last STRIDE slots of a block have three fresh predecessors.
            out_valid <= in_valid && (k >= EMIT_K);
            out_sof   <= in_valid && (k == EMIT_K);
            out_err   <= in_valid && in_sof && (cnt != '0);
            if (in_valid) begin
                cnt       <= k + CNT_W'(1);
                out_idx   <= IDX_W'(k - EMIT_K);
                out_x0_re <= re_3s;
                out_x0_im <= im_3s;
                out_x1_re <= re_2s;
                out_x1_im <= im_2s;
                out_x2_re <= re_s;
                out_x2_im <= im_s;
                out_x3_re <= in_re;
                out_x3_im <= in_im;
            end
        end
    end

endmodule
